// File: rtl/tmds_lane_encoder.sv
// rtl/tmds_lane_encoder.sv - multi-lane TMDS encoder; `define TMDS_LANE_ERRCHK_EN adds sticky o_err flags
module tmds_lane_encoder #(
  parameter int NLANES      = 3,
  parameter int BIT_REVERSE = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic [2:0]           i_dtype,
  input  logic [2*NLANES-1:0]  i_ctl,
  input  logic [4*NLANES-1:0]  i_aux,
  input  logic [8*NLANES-1:0]  i_data,
  output logic [10*NLANES-1:0] o_word,
  output logic                 o_valid
`ifdef TMDS_LANE_ERRCHK_EN
  ,
  output logic [NLANES-1:0]    o_err
`endif
);

  localparam logic [9:0] CTL00_WORD = 10'b1101010100;
  localparam logic [9:0] GUARD_A    = 10'b1011001100;
  localparam logic [9:0] GUARD_B    = 10'b0100110011;
  localparam logic [2:0] DT_VGUARD  = 3'd1;
  localparam logic [2:0] DT_IGUARD  = 3'd2;
  localparam logic [2:0] DT_TERC4   = 3'd3;
  localparam logic [2:0] DT_PIXEL   = 3'd4;

  function automatic logic [9:0] ctl_word(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] terc4(input logic [3:0] a);
    case (a)
      4'h0: return 10'b1010011100;  4'h1: return 10'b1001100011;
      4'h2: return 10'b1011100100;  4'h3: return 10'b1011100010;
      4'h4: return 10'b0101110001;  4'h5: return 10'b0100011110;
      4'h6: return 10'b0110001110;  4'h7: return 10'b0100111100;
      4'h8: return 10'b1011001100;  4'h9: return 10'b0100111001;
      4'ha: return 10'b0110011100;  4'hb: return 10'b1011000110;
      4'hc: return 10'b1010001110;  4'hd: return 10'b1001110001;
      4'he: return 10'b0101100011;  default: return 10'b1011000011;
    endcase
  endfunction

  // Serialiser bit order: reversed puts q_out[9] at the word LSB
  function automatic logic [9:0] bit_order(input logic [9:0] w);
    logic [9:0] r;
    for (int j = 0; j < 10; j++) r[j] = (BIT_REVERSE != 0) ? w[9-j] : w[j];
    return r;
  endfunction

  logic [2:0]            s1_dtype;
  logic [2*NLANES-1:0]   s1_ctl;
  logic [4*NLANES-1:0]   s1_aux;
  logic [9*NLANES-1:0]   s1_qm;
  logic [9*NLANES-1:0]   qm_nxt;
  logic [10*NLANES-1:0]  s2_word;
  logic [10*NLANES-1:0]  s2_word_nxt;
  logic [5*NLANES-1:0]   cnt_q;
  logic [5*NLANES-1:0]   cnt_nxt;
  logic [1:0]            strobe_cnt;

  // Transition-minimised q_m for every lane from the raw pixel byte
  always_comb begin
    logic [7:0] d;
    logic [3:0] n1;
    logic       use_xnor;
    logic       acc;
    qm_nxt   = '0;
    d        = '0;
    n1       = '0;
    use_xnor = 1'b0;
    acc      = 1'b0;
    for (int k = 0; k < NLANES; k++) begin
      d        = i_data[8*k +: 8];
      n1       = 4'($countones(d));
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
      acc      = d[0];
      qm_nxt[9*k] = acc;
      for (int i = 1; i < 8; i++) begin
        acc = use_xnor ? ~(acc ^ d[i]) : (acc ^ d[i]);
        qm_nxt[9*k+i] = acc;
      end
      qm_nxt[9*k+8] = ~use_xnor;
    end
  end

  // DC balance on q_m counts and symbol selection by period type
  always_comb begin
    logic [8:0]        qm;
    logic [3:0]        n1;
    logic [4:0]        cq;
    logic signed [5:0] c6;
    logic signed [5:0] diff6;
    logic signed [5:0] nc6;
    logic [9:0]        bal;
    logic [1:0]        c;
    logic [3:0]        a;
    s2_word_nxt = '0;
    cnt_nxt     = '0;
    qm = '0; n1 = '0; cq = '0; c6 = '0; diff6 = '0; nc6 = '0; bal = '0; c = '0; a = '0;
    for (int k = 0; k < NLANES; k++) begin
      qm    = s1_qm[9*k +: 9];
      cq    = cnt_q[5*k +: 5];
      c     = s1_ctl[2*k +: 2];
      a     = s1_aux[4*k +: 4];
      n1    = 4'($countones(qm[7:0]));
      c6    = $signed({cq[4], cq});
      diff6 = $signed({1'b0, n1, 1'b0}) - 6'sd8;
      if ((cq == 5'd0) || (n1 == 4'd4)) begin
        bal = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        nc6 = qm[8] ? (c6 + diff6) : (c6 - diff6);
      end else if ((!cq[4] && (n1 > 4'd4)) || (cq[4] && (n1 < 4'd4))) begin
        bal = {1'b1, qm[8], ~qm[7:0]};
        nc6 = c6 + $signed({4'b0, qm[8], 1'b0}) - diff6;
      end else begin
        bal = {1'b0, qm[8], qm[7:0]};
        nc6 = c6 - $signed({4'b0, ~qm[8], 1'b0}) + diff6;
      end
      case (s1_dtype)
        DT_PIXEL: begin
          s2_word_nxt[10*k +: 10] = bal;
          cnt_nxt[5*k +: 5]       = nc6[4:0];
        end
        DT_VGUARD: s2_word_nxt[10*k +: 10] = (k == 1) ? GUARD_B : GUARD_A;
        DT_IGUARD: s2_word_nxt[10*k +: 10] = (k == 0) ? terc4({2'b11, c}) : GUARD_B;
        DT_TERC4:  s2_word_nxt[10*k +: 10] = (k == 0) ? terc4({a[3:2], c}) : terc4(a);
        default:   s2_word_nxt[10*k +: 10] = ctl_word(c);
      endcase
    end
  end

  // S1: register period, control, aux and q_m
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_dtype <= '0;
      s1_ctl   <= '0;
      s1_aux   <= '0;
      s1_qm    <= '0;
    end else if (i_ce) begin
      s1_dtype <= i_dtype;
      s1_ctl   <= i_ctl;
      s1_aux   <= i_aux;
      s1_qm    <= qm_nxt;
    end
  end

  // S2: register selected symbol and running disparity
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s2_word <= {NLANES{CTL00_WORD}};
      cnt_q   <= '0;
    end else if (i_ce) begin
      s2_word <= s2_word_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // S3: apply bit order and flag the pipeline as filled after three strobes
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_word     <= {NLANES{bit_order(CTL00_WORD)}};
      o_valid    <= 1'b0;
      strobe_cnt <= '0;
    end else if (i_ce) begin
      for (int k = 0; k < NLANES; k++) o_word[10*k +: 10] <= bit_order(s2_word[10*k +: 10]);
      if (strobe_cnt == 2'd2) o_valid <= 1'b1;
      else strobe_cnt <= strobe_cnt + 2'd1;
    end
  end

`ifdef TMDS_LANE_ERRCHK_EN
  // Sticky per-lane error: illegal period at S1 or disparity out of range
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_err <= '0;
    end else if (i_ce) begin
      for (int k = 0; k < NLANES; k++) begin
        if ((s1_dtype > DT_PIXEL) ||
            ($signed(cnt_q[5*k +: 5]) > 5'sd8) || ($signed(cnt_q[5*k +: 5]) < -5'sd8))
          o_err[k] <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tmds_lane_encoder.sv
// tb/tb_tmds_lane_encoder.sv - scoreboard bench for tmds_lane_encoder (both bit orders)
module tb_tmds_lane_encoder;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_ce = 1'b0;
  logic [2:0]  i_dtype = '0;
  logic [5:0]  i_ctl = '0;
  logic [11:0] i_aux = '0;
  logic [23:0] i_data = '0;
  logic [29:0] w_r, w_n;
  logic        v_r, v_n;
`ifdef TMDS_LANE_ERRCHK_EN
  logic [2:0]  err_r, err_n;
`endif

  always #5 i_clk = ~i_clk;

  tmds_lane_encoder #(.NLANES(3), .BIT_REVERSE(1)) dut_rev (
    .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_dtype(i_dtype),
    .i_ctl(i_ctl), .i_aux(i_aux), .i_data(i_data), .o_word(w_r), .o_valid(v_r)
`ifdef TMDS_LANE_ERRCHK_EN
    , .o_err(err_r)
`endif
  );

  tmds_lane_encoder #(.NLANES(3), .BIT_REVERSE(0)) dut_nat (
    .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_dtype(i_dtype),
    .i_ctl(i_ctl), .i_aux(i_aux), .i_data(i_data), .o_word(w_n), .o_valid(v_n)
`ifdef TMDS_LANE_ERRCHK_EN
    , .o_err(err_n)
`endif
  );

  localparam logic [9:0] T4 [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
  localparam logic [9:0] CW [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  localparam logic [9:0] GA = 10'b1011001100;
  localparam logic [9:0] GB = 10'b0100110011;

  int total = 0;
  int bad = 0;
  int nstrobe = 0;
  int mcnt [3] = '{0, 0, 0};
  logic [29:0] q [$];
  logic [29:0] last_r, last_n;
  logic        last_v;

  function automatic logic [29:0] rev_lanes(input logic [29:0] w);
    logic [29:0] r;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 10; j++) r[10*k+j] = w[10*k+9-j];
    return r;
  endfunction

  task automatic check(input string name, input logic [29:0] got, input logic [29:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  // DVI pixel rule written over integer counts; updates the lane's running disparity
  task automatic pixel_sym(input int k, input logic [7:0] d, output logic [9:0] w);
    int ones, zeros, n1;
    logic xn, q8;
    logic [7:0] qm;
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? !(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    q8 = !xn;
    ones = $countones(qm);
    zeros = 8 - ones;
    if (mcnt[k] == 0 || ones == zeros) begin
      w = {!q8, q8, q8 ? qm : ~qm};
      mcnt[k] += q8 ? (ones - zeros) : (zeros - ones);
    end else if ((mcnt[k] > 0 && ones > zeros) || (mcnt[k] < 0 && zeros > ones)) begin
      w = {1'b1, q8, ~qm};
      mcnt[k] += (q8 ? 2 : 0) + zeros - ones;
    end else begin
      w = {1'b0, q8, qm};
      mcnt[k] += ones - zeros - (q8 ? 0 : 2);
    end
  endtask

  task automatic model_push(input logic [2:0] dt, input logic [5:0] c, input logic [11:0] a, input logic [23:0] d);
    logic [29:0] w;
    logic [9:0]  s;
    logic [1:0]  ck;
    logic [3:0]  ak;
    w = '0;
    for (int k = 0; k < 3; k++) begin
      ck = c[2*k +: 2];
      ak = a[4*k +: 4];
      s  = CW[ck];
      if (dt == 3'd4) pixel_sym(k, d[8*k +: 8], s);
      else begin
        mcnt[k] = 0;
        if (dt == 3'd1) s = (k == 1) ? GB : GA;
        else if (dt == 3'd2) s = (k == 0) ? T4[{2'b11, ck}] : GB;
        else if (dt == 3'd3) s = (k == 0) ? T4[{ak[3:2], ck}] : T4[ak];
      end
      w[10*k +: 10] = s;
    end
    q.push_back(w);
  endtask

  task automatic drive(input logic ce, input logic [2:0] dt, input logic [5:0] c, input logic [11:0] a, input logic [23:0] d);
    @(negedge i_clk);
    i_ce = ce; i_dtype = dt; i_ctl = c; i_aux = a; i_data = d;
    if (ce) model_push(dt, c, a, d);
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) drive(1'b1, 3'd0, 6'd0, 12'd0, 24'd0);
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #3;
    i_reset = 1'b1;
    #1;
    check("reset_word_rev", w_r, rev_lanes({3{CW[0]}}));
    check("reset_word_nat", w_n, {3{CW[0]}});
    check("reset_valid", 30'({v_r, v_n}), 30'd0);
`ifdef TMDS_LANE_ERRCHK_EN
    check("reset_err", 30'({err_r, err_n}), 30'd0);
`endif
    q.delete();
    nstrobe = 0;
    mcnt = '{0, 0, 0};
    last_r = rev_lanes({3{CW[0]}});
    last_n = {3{CW[0]}};
    last_v = 1'b0;
    i_ce = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  // Monitor: after every edge, pop and compare on strobes, check hold otherwise
  always @(posedge i_clk) begin
    logic [29:0] e;
    #1;
    if (!i_reset) begin
      if (i_ce) begin
        nstrobe++;
        if (nstrobe < 3) begin
          check("prefill_valid", 30'({v_r, v_n}), 30'd0);
          check("prefill_word_rev", w_r, rev_lanes({3{CW[0]}}));
          check("prefill_word_nat", w_n, {3{CW[0]}});
        end else begin
          check("valid", 30'({v_r, v_n}), 30'd3);
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty got=none want=entry at %0t", $time);
          end else begin
            e = q.pop_front();
            check("word_nat", w_n, e);
            check("word_rev", w_r, rev_lanes(e));
          end
        end
      end else begin
        check("hold_rev", w_r, last_r);
        check("hold_nat", w_n, last_n);
        check("hold_valid", 30'(v_r), 30'(last_v));
      end
      last_r = w_r;
      last_n = w_n;
      last_v = v_r;
    end
  end

  initial begin
    logic [2:0] dt;
    int run;
    do_reset();
    // control period ctl=00
    for (int i = 0; i < 6; i++) drive(1'b1, 3'd0, 6'd0, 12'd0, 24'd0);
    // pixel 0x00 for 10 strobes
    for (int i = 0; i < 10; i++) drive(1'b1, 3'd4, 6'd0, 12'd0, 24'h000000);
    flush();
    // island guard with ctl=10, then video guard
    for (int i = 0; i < 2; i++) drive(1'b1, 3'd2, 6'b10_10_10, 12'($urandom), 24'($urandom));
    for (int i = 0; i < 2; i++) drive(1'b1, 3'd1, 6'($urandom), 12'($urandom), 24'($urandom));
    // pixel x3, one control strobe, pixel again
    for (int i = 0; i < 3; i++) drive(1'b1, 3'd4, 6'd0, 12'd0, 24'h000000);
    drive(1'b1, 3'd0, 6'd0, 12'd0, 24'd0);
    for (int i = 0; i < 2; i++) drive(1'b1, 3'd4, 6'd0, 12'd0, 24'h000000);
    // clock-enable gaps with changing inputs
    drive(1'b1, 3'd3, 6'($urandom), 12'($urandom), 24'($urandom));
    drive(1'b0, 3'd4, 6'($urandom), 12'($urandom), 24'($urandom));
    drive(1'b0, 3'd2, 6'($urandom), 12'($urandom), 24'($urandom));
    drive(1'b1, 3'd4, 6'($urandom), 12'($urandom), 24'($urandom));
    flush();
`ifdef TMDS_LANE_ERRCHK_EN
    drive(1'b1, 3'd7, 6'($urandom), 12'($urandom), 24'($urandom));
    flush();
    check("err_sticky_rev", 30'(err_r), 30'h7);
    check("err_sticky_nat", 30'(err_n), 30'h7);
`endif
    // reset in the middle of a pixel period
    for (int i = 0; i < 5; i++) drive(1'b1, 3'd4, 6'd0, 12'd0, 24'($urandom));
    do_reset();
    // randomized periods of random length, random enable
    for (int r = 0; r < 60; r++) begin
      dt  = ($urandom_range(0, 1) == 1) ? 3'd4 : 3'($urandom_range(0, 7));
      run = $urandom_range(1, 12);
      for (int i = 0; i < run; i++)
        drive(($urandom_range(0, 3) != 0), dt, 6'($urandom), 12'($urandom), 24'($urandom));
    end
    flush();
    for (int i = 0; i < 3; i++) drive(1'b1, 3'd4, 6'd0, 12'd0, 24'($urandom));
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 3'd4, 6'd0, 12'd0, 24'($urandom));
    flush();
    @(negedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
